// File: rtl/nanop_sequencer.sv
// nanop_sequencer -- control sequencer for an 8-bit nanoprocessor.
//
// Fetches an opcode, then zero, one or two operand bytes, and finishes
// with a write-back cycle for ALU instructions. Strobes are decoded
// combinationally from the state and the instruction register, so they
// are stable well before the falling-edge memory access.
//
// Opcode map (anything else halts the sequencer):
//   00 NOP  01 XOR  02 AND  03 OR   04 ADD  05 ADC  06 SUB  07 SBC
//   08 ROL  09 ROR  0C OUT  0D JMP  0E JNC  0F JNZ
//
// Ports:
//   clk        system clock, rising-edge state changes
//   reset      synchronous active-high reset
//   run        1 = execute, 0 = stall at the next instruction boundary
//   DIN[7:0]   memory read data for the address driven this cycle
//   alu_c      ALU carry result, captured into C in write-back
//   alu_z      ALU zero result, captured into Z in write-back
//   ADDR[7:0]  memory address (the program counter)
//   WRITE      memory write strobe (write-back cycle)
//   Load_I     instruction register load enable
//   Load_op1   operand 1 register load enable
//   Load_op2   operand 2 register load enable
//   Load_out   LED output register load enable
//   carry_in   registered C flag for ADC/SBC/ROL/ROR
//   halted     high while stopped on an illegal opcode
//   opcode     instruction register contents, fed to the ALU
module nanop_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] DIN,
  input  logic       alu_c,
  input  logic       alu_z,
  output logic [7:0] ADDR,
  output logic       WRITE,
  output logic       Load_I,
  output logic       Load_op1,
  output logic       Load_op2,
  output logic       Load_out,
  output logic       carry_in,
  output logic       halted,
  output logic [7:0] opcode
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_OP1   = 3'd1,
    S_OP2   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Instruction classes, used to decide what follows OP1.
  typedef enum logic [2:0] {
    CL_ALU2 = 3'd0,
    CL_ROT  = 3'd1,
    CL_OUT  = 3'd2,
    CL_JMP  = 3'd3,
    CL_JNC  = 3'd4,
    CL_JNZ  = 3'd5,
    CL_ILL  = 3'd6
  } class_t;

  localparam logic [7:0] OP_NOP = 8'h00;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  class_t     cls_s;
  logic [7:0] pc_inc_s;

  // Wraps naturally at 8 bits: 0xFF + 1 = 0x00.
  assign pc_inc_s = pc_q + 8'd1;

  // Classify the held instruction.
  always_comb begin
    cls_s = CL_ILL;
    case (ir_q)
      8'h01, 8'h02, 8'h03, 8'h04,
      8'h05, 8'h06, 8'h07: cls_s = CL_ALU2;
      8'h08, 8'h09:        cls_s = CL_ROT;
      8'h0C:               cls_s = CL_OUT;
      8'h0D:               cls_s = CL_JMP;
      8'h0E:               cls_s = CL_JNC;
      8'h0F:               cls_s = CL_JNZ;
      default:             cls_s = CL_ILL;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Next-state, PC, IR and flag computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = DIN;
          pc_d    = pc_inc_s;
          // A NOP completes in its fetch cycle.
          state_d = (DIN == OP_NOP) ? S_FETCH : S_OP1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_OP1: begin
        case (cls_s)
          CL_ALU2: begin pc_d = pc_inc_s; state_d = S_OP2;   end
          CL_ROT:  begin pc_d = pc_inc_s; state_d = S_WB;    end
          CL_OUT:  begin pc_d = pc_inc_s; state_d = S_FETCH; end
          CL_JMP:  begin pc_d = DIN;      state_d = S_FETCH; end
          CL_JNC:  begin pc_d = c_q ? pc_inc_s : DIN; state_d = S_FETCH; end
          CL_JNZ:  begin pc_d = z_q ? pc_inc_s : DIN; state_d = S_FETCH; end
          default: begin pc_d = pc_q;     state_d = S_HALT;  end
        endcase
      end
      S_OP2: begin
        pc_d    = pc_inc_s;
        state_d = S_WB;
      end
      S_WB: begin
        c_d     = alu_c;
        z_d     = alu_z;
        pc_d    = pc_inc_s;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        // Unused encodings are treated as a fault and parked in HALT.
        state_d = S_HALT;
      end
    endcase
  end

  // Strobe decode; reset forces everything quiet so an aborted
  // instruction can never write.
  always_comb begin
    ADDR     = 8'h00;
    WRITE    = 1'b0;
    Load_I   = 1'b0;
    Load_op1 = 1'b0;
    Load_op2 = 1'b0;
    Load_out = 1'b0;
    halted   = 1'b0;
    if (reset) begin
      ADDR = 8'h00;
    end else begin
      ADDR = pc_q;
      case (state_q)
        S_FETCH: Load_I = run;
        S_OP1: begin
          Load_op1 = (cls_s != CL_ILL);
          Load_out = (cls_s == CL_OUT);
        end
        S_OP2:   Load_op2 = 1'b1;
        S_WB:    WRITE    = 1'b1;
        S_HALT:  halted   = 1'b1;
        default: halted   = 1'b1;
      endcase
    end
  end

  assign carry_in = c_q;
  assign opcode   = ir_q;

endmodule

// File: tb/tb_nanop_sequencer.sv
module tb_nanop_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] DIN;
  logic       alu_c;
  logic       alu_z;
  logic [7:0] ADDR;
  logic       WRITE;
  logic       Load_I;
  logic       Load_op1;
  logic       Load_op2;
  logic       Load_out;
  logic       carry_in;
  logic       halted;
  logic [7:0] opcode;

  logic [7:0] mem [256];
  logic [5:0] flags;
  int vectors;
  int miscompares;

  // Flag vector order: {WRITE, Load_I, Load_op1, Load_op2, Load_out, halted}
  localparam logic [5:0] F_0   = 6'b000000;
  localparam logic [5:0] F_W   = 6'b100000;
  localparam logic [5:0] F_I   = 6'b010000;
  localparam logic [5:0] F_1   = 6'b001000;
  localparam logic [5:0] F_2   = 6'b000100;
  localparam logic [5:0] F_OUT = 6'b001010;
  localparam logic [5:0] F_H   = 6'b000001;

  typedef struct {
    logic       rst;
    logic       run;
    logic [7:0] addr;
    logic [5:0] fl;
    logic       cin;
  } row_t;

  nanop_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .DIN      (DIN),
    .alu_c    (alu_c),
    .alu_z    (alu_z),
    .ADDR     (ADDR),
    .WRITE    (WRITE),
    .Load_I   (Load_I),
    .Load_op1 (Load_op1),
    .Load_op2 (Load_op2),
    .Load_out (Load_out),
    .carry_in (carry_in),
    .halted   (halted),
    .opcode   (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign DIN   = mem[ADDR];
  assign flags = {WRITE, Load_I, Load_op1, Load_op2, Load_out, halted};

  function automatic row_t rw(input logic rst, input logic rn, input logic [7:0] a,
                              input logic [5:0] f, input logic c);
    row_t r;
    r.rst = rst; r.run = rn; r.addr = a; r.fl = f; r.cin = c;
    return r;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Ends aligned on a falling edge with the DUT freshly reset (FETCH, PC=0).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    row_t q[$];
    clear_mem();
    alu_c = 1'b0; alu_z = 1'b0;
    do_reset();
    q.push_back(rw(1'b1, 1'b1, 8'h00, F_0, 1'b0));
    q.push_back(rw(1'b0, 1'b0, 8'h00, F_0, 1'b0));
    q.push_back(rw(1'b0, 1'b0, 8'h00, F_0, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_I, 1'b0));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL reset row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
    vectors++;
    if (opcode !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_opcode: got %02h, want 00", opcode);
    end
  endtask

  task automatic test_alu_op();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'h03; mem[2] = 8'h04;
    alu_c = 1'b0; alu_z = 1'b0;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h02, F_2, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h03, F_W, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h04, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h05, F_I, 1'b0));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL alu_op row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
  endtask

  // ADC with alu_c held high: C changes only at write-back, then JNC falls through.
  task automatic test_carry();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h11; mem[2] = 8'h22;
    mem[4] = 8'h0E; mem[5] = 8'h40;
    alu_c = 1'b1; alu_z = 1'b0;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h02, F_2, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h03, F_W, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h04, F_I, 1'b1));
    q.push_back(rw(1'b0, 1'b1, 8'h05, F_1, 1'b1));
    q.push_back(rw(1'b0, 1'b1, 8'h06, F_I, 1'b1));
    q.push_back(rw(1'b0, 1'b1, 8'h07, F_I, 1'b1));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL carry row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
  endtask

  // SUB with Z=1, JNZ not taken, then JMP 0x20.
  task automatic test_jnz_jmp();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h06; mem[1] = 8'h05; mem[2] = 8'h05;
    mem[4] = 8'h0F; mem[5] = 8'h20; mem[6] = 8'h0D; mem[7] = 8'h20;
    alu_c = 1'b0; alu_z = 1'b1;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h02, F_2, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h03, F_W, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h04, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h05, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h06, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h07, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h20, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h21, F_I, 1'b0));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL jnz_jmp row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
  endtask

  // ROL clears C and Z, so JNC and JNZ are both taken.
  task automatic test_taken_jumps();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h08; mem[1] = 8'h77;
    mem[3] = 8'h0E; mem[4] = 8'h40;
    mem[8'h40] = 8'h0F; mem[8'h41] = 8'h60;
    alu_c = 1'b0; alu_z = 1'b0;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h02, F_W, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h03, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h04, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h40, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h41, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h60, F_I, 1'b0));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL taken_jumps row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_out();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h0D; mem[1] = 8'h10; mem[8'h10] = 8'h0C; mem[8'h11] = 8'hA5;
    alu_c = 1'b0; alu_z = 1'b0;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I,   1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1,   1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h10, F_I,   1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h11, F_OUT, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h12, F_I,   1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h13, F_I,   1'b0));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL out row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      if (i == 3) begin
        vectors++;
        if (opcode !== 8'h0C) begin
          miscompares++;
          $display("FAIL out_opcode: got %02h, want 0C", opcode);
        end
      end
      @(negedge clk);
    end
  endtask

  // Opcode 0x20 at 0x08: halt for 20 cycles, then reset recovers.
  task automatic test_halt();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h0D; mem[1] = 8'h08; mem[8] = 8'h20;
    alu_c = 1'b1; alu_z = 1'b1;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h08, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h09, F_0, 1'b0));
    for (int k = 0; k < 20; k++) q.push_back(rw(1'b0, 1'b1, 8'h09, F_H, 1'b0));
    q.push_back(rw(1'b1, 1'b1, 8'h00, F_0, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL halt row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] ops [4];
    ops[0] = 8'h0A; ops[1] = 8'h0B; ops[2] = 8'h10; ops[3] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      row_t q[$];
      clear_mem();
      mem[0] = ops[k];
      alu_c = 1'b0; alu_z = 1'b0;
      do_reset();
      q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
      q.push_back(rw(1'b0, 1'b1, 8'h01, F_0, 1'b0));
      q.push_back(rw(1'b0, 1'b1, 8'h01, F_H, 1'b0));
      q.push_back(rw(1'b0, 1'b1, 8'h01, F_H, 1'b0));
      foreach (q[i]) begin
        reset = q[i].rst; run = q[i].run; #1;
        vectors++;
        if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
          miscompares++;
          $display("FAIL illegal_%02h row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                   ops[k], i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
        end
        @(negedge clk);
      end
      vectors++;
      if (opcode !== ops[k]) begin
        miscompares++;
        $display("FAIL illegal_opcode: got %02h, want %02h", opcode, ops[k]);
      end
    end
  endtask

  // run dropped during OP2 of an ADD: instruction completes, then fetch stalls.
  task automatic test_stall();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'h01; mem[2] = 8'h02; mem[4] = 8'h04;
    alu_c = 1'b0; alu_z = 1'b0;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b0, 8'h02, F_2, 1'b0));
    q.push_back(rw(1'b0, 1'b0, 8'h03, F_W, 1'b0));
    q.push_back(rw(1'b0, 1'b0, 8'h04, F_0, 1'b0));
    q.push_back(rw(1'b0, 1'b0, 8'h04, F_0, 1'b0));
    q.push_back(rw(1'b0, 1'b0, 8'h04, F_0, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h04, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h05, F_1, 1'b0));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL stall row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'h01; mem[2] = 8'h02;
    alu_c = 1'b1; alu_z = 1'b1;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    q.push_back(rw(1'b1, 1'b1, 8'h00, F_0, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL reset_mid row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
  endtask

  // ROR at 0xFE: operand at 0xFF, write-back at 0x00, next fetch at 0x01
  // (which holds 0xFE, an illegal opcode, so it then halts at 0x02).
  task automatic test_wrap();
    row_t q[$];
    clear_mem();
    mem[0] = 8'h0D; mem[1] = 8'hFE; mem[8'hFE] = 8'h09; mem[8'hFF] = 8'h33;
    alu_c = 1'b1; alu_z = 1'b0;
    do_reset();
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'hFE, F_I, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'hFF, F_1, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h00, F_W, 1'b0));
    q.push_back(rw(1'b0, 1'b1, 8'h01, F_I, 1'b1));
    q.push_back(rw(1'b0, 1'b1, 8'h02, F_0, 1'b1));
    q.push_back(rw(1'b0, 1'b1, 8'h02, F_H, 1'b1));
    foreach (q[i]) begin
      reset = q[i].rst; run = q[i].run; #1;
      vectors++;
      if (ADDR !== q[i].addr || flags !== q[i].fl || carry_in !== q[i].cin) begin
        miscompares++;
        $display("FAIL wrap row %0d: got ADDR=%02h flags=%06b C=%b, want ADDR=%02h flags=%06b C=%b",
                 i, ADDR, flags, carry_in, q[i].addr, q[i].fl, q[i].cin);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    run         = 1'b0;
    alu_c       = 1'b0;
    alu_z       = 1'b0;
    clear_mem();
    test_reset();
    test_alu_op();
    test_carry();
    test_jnz_jmp();
    test_taken_jumps();
    test_out();
    test_halt();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
